// File: rtl/proc_clk_ctrl_pkg.sv
// Shared definitions for the processor clock-enable controller:
// stall FSM state encodings and the default parameter values.
package proc_clk_ctrl_pkg;

    typedef enum logic {
        STATE_RUN   = 1'b0,
        STATE_STALL = 1'b1
    } state_t;

    localparam int DEFAULT_NUM_STALL = 2;
    localparam int DEFAULT_DIV_W     = 4;
    localparam int DEFAULT_TO_W      = 8;
    localparam int DEFAULT_TIMEOUT   = 200;

endpackage

// File: rtl/proc_clk_ctrl_if.sv
// Bus between the processor-side logic and the clock-enable controller.
// master = the side that drives divide select, stall requests and err_clr;
// slave  = the controller itself.
interface proc_clk_ctrl_if
    import proc_clk_ctrl_pkg::*;
#(
    parameter int NUM_STALL = DEFAULT_NUM_STALL,
    parameter int DIV_W     = DEFAULT_DIV_W
);

    logic [DIV_W-1:0]     div_sel;
    logic [NUM_STALL-1:0] stall_req;
    logic                 err_clr;
    logic                 clk_en;
    logic                 stall_active;
    logic [NUM_STALL-1:0] stall_src;
    logic                 timeout_err;
    logic [31:0]          tick_count;

    modport master (
        output div_sel, stall_req, err_clr,
        input  clk_en, stall_active, stall_src, timeout_err, tick_count
    );

    modport slave (
        input  div_sel, stall_req, err_clr,
        output clk_en, stall_active, stall_src, timeout_err, tick_count
    );

endinterface

// File: rtl/proc_clk_ctrl_clk_divider.sv
// Programmable tick divider: counts 0..period_q and flags terminal count.
// The period is only reloaded at terminal count so a div_sel change never
// truncates or stretches the period already in progress.
module proc_clk_ctrl_clk_divider
    import proc_clk_ctrl_pkg::*;
#(
    parameter int DIV_W = DEFAULT_DIV_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] div_sel,
    output logic             tc
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] period_q;

    assign tc = (cnt_q == period_q);

    // Free-running period counter; wraps and captures the new period at TC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            period_q <= '0;
        end else if (tc) begin
            cnt_q    <= '0;
            period_q <= div_sel;
        end else begin
            cnt_q    <= cnt_q + DIV_W'(1);
        end
    end

endmodule

// File: rtl/proc_clk_ctrl.sv
// Processor clock-enable controller. Produces a one-cycle clk_en at each
// divider terminal count unless an unmasked stall source is active, records
// which sources caused a stall, counts retired ticks, and forces a release
// (masking the offending sources) when a stall outlives TIMEOUT cycles.
// TIMEOUT must lie in 1..2**TO_W-1.
module proc_clk_ctrl
    import proc_clk_ctrl_pkg::*;
#(
    parameter int NUM_STALL = DEFAULT_NUM_STALL,
    parameter int DIV_W     = DEFAULT_DIV_W,
    parameter int TO_W      = DEFAULT_TO_W,
    parameter int TIMEOUT   = DEFAULT_TIMEOUT
) (
    input  logic           clk,
    input  logic           rst,
    proc_clk_ctrl_if.slave bus
);

    state_t               state_q;
    state_t               state_d;
    logic                 tc;
    logic [NUM_STALL-1:0] eff;
    logic [NUM_STALL-1:0] mask_q;
    logic [NUM_STALL-1:0] mask_d;
    logic [NUM_STALL-1:0] src_q;
    logic [TO_W-1:0]      timer_q;
    logic                 timer_full;
    logic                 err_q;
    logic [31:0]          ticks_q;
    logic                 clk_en_c;
    logic                 enter_stall;
    logic                 timeout_hit;

    proc_clk_ctrl_clk_divider #(
        .DIV_W (DIV_W)
    ) u_div (
        .clk     (clk),
        .rst     (rst),
        .div_sel (bus.div_sel),
        .tc      (tc)
    );

    // Sources that timed out stay masked until they drop or err_clr.
    assign eff        = bus.stall_req & ~mask_q;
    assign timer_full = (timer_q == TO_W'(TIMEOUT - 1));

    // Stall FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= STATE_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: requests are only sampled at terminal count; a release at
    // TC beats a simultaneous timeout.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            STATE_RUN: begin
                if (tc && (eff != '0)) begin
                    state_d = STATE_STALL;
                end
            end
            STATE_STALL: begin
                if (tc && (eff == '0)) begin
                    state_d = STATE_RUN;
                end else if (timer_full) begin
                    state_d = STATE_RUN;
                end
            end
            default: state_d = STATE_RUN;
        endcase
    end

    // FSM outputs: tick pulse, stall entry strobe and forced-release strobe.
    always_comb begin
        clk_en_c    = 1'b0;
        enter_stall = 1'b0;
        timeout_hit = 1'b0;
        unique case (state_q)
            STATE_RUN: begin
                if (tc) begin
                    if (eff == '0) begin
                        clk_en_c = 1'b1;
                    end else begin
                        enter_stall = 1'b1;
                    end
                end
            end
            STATE_STALL: begin
                if (tc && (eff == '0)) begin
                    clk_en_c = 1'b1;
                end else if (timer_full) begin
                    timeout_hit = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Mask update: a timeout's set takes priority over err_clr and auto-clear.
    always_comb begin
        mask_d = bus.err_clr ? '0 : (mask_q & bus.stall_req);
        if (timeout_hit) begin
            mask_d = mask_d | src_q;
        end
    end

    // Stall bookkeeping, error flag, mask and retired-tick counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_q <= '0;
            src_q   <= '0;
            err_q   <= 1'b0;
            mask_q  <= '0;
            ticks_q <= '0;
        end else begin
            if (enter_stall) begin
                timer_q <= '0;
                src_q   <= eff;
            end else if (state_q == STATE_STALL) begin
                timer_q <= timer_q + TO_W'(1);
            end
            if (timeout_hit) begin
                err_q <= 1'b1;
            end else if (bus.err_clr) begin
                err_q <= 1'b0;
            end
            mask_q <= mask_d;
            if (clk_en_c) begin
                ticks_q <= ticks_q + 32'd1;
            end
        end
    end

    // The enable is forced low while reset is held so the core never ticks
    // during reset even though the divider sits at terminal count.
    assign bus.clk_en       = clk_en_c & ~rst;
    assign bus.stall_active = (state_q == STATE_STALL);
    assign bus.stall_src    = src_q;
    assign bus.timeout_err  = err_q;
    assign bus.tick_count   = ticks_q;

endmodule

// File: tb/tb_proc_clk_ctrl.sv
// Testbench for proc_clk_ctrl: a fixed vector table for the basic tick and
// stall behaviour, hand sequences for multi-source, timeout and reset cases,
// then random stimulus against a cycle-level reference model.
module tb_proc_clk_ctrl;

    localparam int NUM_STALL = 2;
    localparam int DIV_W     = 4;
    localparam int TO_W      = 8;
    localparam int TIMEOUT   = 200;

    logic clk = 1'b0;
    logic rst = 1'b1;

    proc_clk_ctrl_if #(.NUM_STALL(NUM_STALL), .DIV_W(DIV_W)) bus ();

    proc_clk_ctrl #(
        .NUM_STALL (NUM_STALL),
        .DIV_W     (DIV_W),
        .TO_W      (TO_W),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  div_sel;
        logic [1:0]  stall_req;
        logic        err_clr;
        logic        exp_en;
        logic        exp_active;
        logic [1:0]  exp_src;
        logic        exp_err;
        logic [31:0] exp_ticks;
    } vec_t;

    vec_t vecs[$];

    // Reference model state, expressed as plain counts and flags.
    int          m_pos;
    int          m_period;
    bit          m_stalled;
    int          m_stall_cycles;
    logic [1:0]  m_src;
    logic [1:0]  m_mask;
    bit          m_err;
    logic [31:0] m_ticks;

    function automatic vec_t mk(input logic [3:0] ds, input logic [1:0] rq, input logic clr,
                                input logic en, input logic sa, input logic [1:0] src,
                                input logic er, input logic [31:0] tk);
        vec_t v;
        v.div_sel = ds; v.stall_req = rq; v.err_clr = clr;
        v.exp_en = en; v.exp_active = sa; v.exp_src = src; v.exp_err = er; v.exp_ticks = tk;
        return v;
    endfunction

    task automatic resetModel();
        m_pos = 0; m_period = 0; m_stalled = 0; m_stall_cycles = 0;
        m_src = '0; m_mask = '0; m_err = 0; m_ticks = '0;
    endtask

    // The processor ticks at the end of each period unless some unmasked source is asking.
    function automatic bit modelEn();
        return !rst && (m_pos == m_period) && ((bus.stall_req & ~m_mask) == 2'b00);
    endfunction

    task automatic modelStep();
        bit         period_end;
        bit         en;
        bit         forced;
        logic [1:0] want;
        period_end = (m_pos == m_period);
        want       = bus.stall_req & ~m_mask;
        en         = modelEn();
        forced     = m_stalled && !en && (m_stall_cycles == TIMEOUT);
        if (en) m_ticks = m_ticks + 32'd1;
        m_mask = bus.err_clr ? 2'b00 : (m_mask & bus.stall_req);
        if (forced) begin
            m_mask = m_mask | m_src;
            m_err  = 1;
        end else if (bus.err_clr) begin
            m_err = 0;
        end
        if (!m_stalled) begin
            if (period_end && want != 2'b00) begin
                m_stalled = 1; m_src = want; m_stall_cycles = 1;
            end
        end else if (en || forced) begin
            m_stalled = 0;
        end else begin
            m_stall_cycles++;
        end
        if (period_end) begin
            m_pos = 0; m_period = int'(bus.div_sel);
        end else begin
            m_pos++;
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic checkAgainstModel(input string tag);
        checkOutput({tag, "_clk_en"},       32'(bus.clk_en),       32'(modelEn()));
        checkOutput({tag, "_stall_active"}, 32'(bus.stall_active), 32'(m_stalled));
        checkOutput({tag, "_stall_src"},    32'(bus.stall_src),    32'(m_src));
        checkOutput({tag, "_timeout_err"},  32'(bus.timeout_err),  32'(m_err));
        checkOutput({tag, "_tick_count"},   bus.tick_count,        m_ticks);
    endtask

    // Drive one cycle's inputs just after the rising edge and move to the sample point.
    task automatic applyStimulus(input logic [3:0] ds, input logic [1:0] rq, input logic clr);
        bus.div_sel   = ds;
        bus.stall_req = rq;
        bus.err_clr   = clr;
        @(negedge clk);
    endtask

    task automatic finishCycle();
        modelStep();
        @(posedge clk);
        #1;
    endtask

    task automatic cycleModel(input logic [3:0] ds, input logic [1:0] rq, input logic clr, input string tag);
        applyStimulus(ds, rq, clr);
        checkAgainstModel(tag);
        finishCycle();
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int         first_err;
        logic [31:0] t_resume;
        logic [3:0]  ds;
        logic [1:0]  rq;
        int          len;
        int          done;

        bus.div_sel = '0; bus.stall_req = '0; bus.err_clr = 1'b0;
        resetModel();

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_clk_en",       32'(bus.clk_en),       32'd0);
        checkOutput("reset_stall_active", 32'(bus.stall_active), 32'd0);
        checkOutput("reset_stall_src",    32'(bus.stall_src),    32'd0);
        checkOutput("reset_timeout_err",  32'(bus.timeout_err),  32'd0);
        checkOutput("reset_tick_count",   bus.tick_count,        32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Table: free-running ticks, single-source stall, divider changes
        for (int k = 1; k <= 10; k++) vecs.push_back(mk(4'd0, 2'b00, 0, 1, 0, 2'b00, 0, 32'(k - 1)));
        vecs.push_back(mk(4'd0, 2'b01, 0, 0, 0, 2'b00, 0, 32'd10));
        for (int k = 0; k < 4; k++) vecs.push_back(mk(4'd0, 2'b01, 0, 0, 1, 2'b01, 0, 32'd10));
        vecs.push_back(mk(4'd0, 2'b00, 0, 1, 1, 2'b01, 0, 32'd10));
        vecs.push_back(mk(4'd0, 2'b00, 0, 1, 0, 2'b01, 0, 32'd11));
        vecs.push_back(mk(4'd0, 2'b00, 0, 1, 0, 2'b01, 0, 32'd12));
        vecs.push_back(mk(4'd3, 2'b00, 0, 1, 0, 2'b01, 0, 32'd13));
        for (int k = 0; k < 3; k++) vecs.push_back(mk(4'd3, 2'b00, 0, 0, 0, 2'b01, 0, 32'd14));
        vecs.push_back(mk(4'd3, 2'b00, 0, 1, 0, 2'b01, 0, 32'd14));
        for (int k = 0; k < 3; k++) vecs.push_back(mk(4'd3, 2'b00, 0, 0, 0, 2'b01, 0, 32'd15));
        vecs.push_back(mk(4'd3, 2'b00, 0, 1, 0, 2'b01, 0, 32'd15));
        for (int k = 0; k < 3; k++) vecs.push_back(mk(4'd1, 2'b00, 0, 0, 0, 2'b01, 0, 32'd16));
        vecs.push_back(mk(4'd1, 2'b00, 0, 1, 0, 2'b01, 0, 32'd16));
        vecs.push_back(mk(4'd1, 2'b00, 0, 0, 0, 2'b01, 0, 32'd17));
        vecs.push_back(mk(4'd1, 2'b00, 0, 1, 0, 2'b01, 0, 32'd17));
        vecs.push_back(mk(4'd1, 2'b00, 0, 0, 0, 2'b01, 0, 32'd18));
        vecs.push_back(mk(4'd1, 2'b00, 0, 1, 0, 2'b01, 0, 32'd18));
        vecs.push_back(mk(4'd0, 2'b00, 0, 0, 0, 2'b01, 0, 32'd19));
        vecs.push_back(mk(4'd0, 2'b00, 0, 1, 0, 2'b01, 0, 32'd19));
        vecs.push_back(mk(4'd0, 2'b00, 0, 1, 0, 2'b01, 0, 32'd20));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].div_sel, vecs[i].stall_req, vecs[i].err_clr);
            checkOutput($sformatf("vec%0d_clk_en", i),       32'(bus.clk_en),       32'(vecs[i].exp_en));
            checkOutput($sformatf("vec%0d_stall_active", i), 32'(bus.stall_active), 32'(vecs[i].exp_active));
            checkOutput($sformatf("vec%0d_stall_src", i),    32'(bus.stall_src),    32'(vecs[i].exp_src));
            checkOutput($sformatf("vec%0d_timeout_err", i),  32'(bus.timeout_err),  32'(vecs[i].exp_err));
            checkOutput($sformatf("vec%0d_tick_count", i),   bus.tick_count,        vecs[i].exp_ticks);
            finishCycle();
        end

        // Two sources together; release needs both low
        for (int k = 0; k < 3; k++) cycleModel(4'd0, 2'b11, 0, "t4_both");
        for (int k = 0; k < 3; k++) begin
            applyStimulus(4'd0, 2'b10, 0);
            checkAgainstModel("t4_one");
            checkOutput("t4_hold_active", 32'(bus.stall_active), 32'd1);
            checkOutput("t4_hold_src",    32'(bus.stall_src),    32'd3);
            finishCycle();
        end
        applyStimulus(4'd0, 2'b00, 0);
        checkAgainstModel("t4_release");
        checkOutput("t4_release_en", 32'(bus.clk_en), 32'd1);
        finishCycle();
        cycleModel(4'd0, 2'b00, 0, "t4_after");

        // Timeout on a held source, then masked ticking
        first_err = -1;
        t_resume  = '0;
        for (int k = 0; k < 300; k++) begin
            applyStimulus(4'd0, 2'b10, 0);
            checkAgainstModel("t5_hold");
            if (bus.timeout_err && first_err < 0) first_err = k;
            if (k == 201) t_resume = bus.tick_count;
            if (k == 299) checkOutput("t5_resume_ticks", bus.tick_count - t_resume, 32'd98);
            finishCycle();
        end
        checkOutput("t5_err_cycle", 32'(first_err), 32'd201);

        // Drop and re-raise: stalls again; err_clr clears, then set wins over err_clr
        cycleModel(4'd0, 2'b00, 0, "t5_drop");
        cycleModel(4'd0, 2'b00, 0, "t5_drop");
        for (int j = 0; j < 206; j++) begin
            applyStimulus(4'd0, 2'b10, (j == 5 || j == 200));
            checkAgainstModel("t5_again");
            if (j == 1)   checkOutput("t5_restall",    32'(bus.stall_active), 32'd1);
            if (j == 6)   checkOutput("t5_err_clr",    32'(bus.timeout_err),  32'd0);
            if (j == 201) checkOutput("t5_set_wins",   32'(bus.timeout_err),  32'd1);
            finishCycle();
        end
        for (int k = 0; k < 3; k++) cycleModel(4'd0, 2'b00, 0, "t5_idle");
        cycleModel(4'd0, 2'b00, 1, "t5_clear");
        applyStimulus(4'd0, 2'b00, 0);
        checkAgainstModel("t5_cleared");
        checkOutput("t5_cleared_err", 32'(bus.timeout_err), 32'd0);
        finishCycle();

        // Reset during a stall with 57 ticks retired
        rst = 1'b1;
        resetModel();
        @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 57; k++) cycleModel(4'd0, 2'b00, 0, "t6_run");
        for (int k = 0; k < 4; k++) begin
            applyStimulus(4'd0, 2'b01, 0);
            checkAgainstModel("t6_stall");
            checkOutput("t6_ticks", bus.tick_count, 32'd57);
            finishCycle();
        end
        bus.stall_req = 2'b00;
        #2 rst = 1'b1;
        #1;
        checkOutput("t6_rst_clk_en",       32'(bus.clk_en),       32'd0);
        checkOutput("t6_rst_stall_active", 32'(bus.stall_active), 32'd0);
        checkOutput("t6_rst_stall_src",    32'(bus.stall_src),    32'd0);
        checkOutput("t6_rst_tick_count",   bus.tick_count,        32'd0);
        resetModel();
        @(posedge clk);
        #1 rst = 1'b0;
        applyStimulus(4'd2, 2'b00, 0);
        checkAgainstModel("t6_first");
        checkOutput("t6_first_en", 32'(bus.clk_en), 32'd1);
        finishCycle();

        // Random stimulus against the model
        ds   = 4'd2;
        done = 0;
        while (done < 1500) begin
            rq  = 2'($urandom_range(0, 3));
            len = ($urandom_range(0, 19) == 0) ? 220 : int'($urandom_range(1, 12));
            if ($urandom_range(0, 7) == 0) ds = 4'($urandom_range(0, 3));
            for (int k = 0; k < len; k++) begin
                cycleModel(ds, rq, ($urandom_range(0, 29) == 0), "rand");
            end
            done += len;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
